// File: rtl/fetch_stage_pkg.sv
// Shared CPU types for the fetch stage.
// Word type, fetch FSM states and PC increment.
package cpu_types_pkg;

  localparam int WORD_W  = 32;
  localparam int PC_STEP = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory port between fetch and imem.
// master = fetch side, slave = memory side.
interface fetch_stage_if #(
  parameter int WORD_W = 32
);

  logic              ihit;
  logic [WORD_W-1:0] iload;
  logic              imemREN;
  logic [WORD_W-1:0] imemaddr;

  modport master (
    input  ihit,
    input  iload,
    output imemREN,
    output imemaddr
  );

  modport slave (
    output ihit,
    output iload,
    input  imemREN,
    input  imemaddr
  );

endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, feeds IF/ID.
// Redirects behind a miss are parked in pend_pc until the miss drains.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int          WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  fetch_stage_if.master     imem,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pcp4,
  output logic              fetch_valid,
  output logic              fetch_flush,
  output logic [WORD_W-1:0] pc
);

  fetch_state_t      state, state_n;
  logic [WORD_W-1:0] pc_n;
  logic [WORD_W-1:0] pend_pc, pend_n;
  logic [WORD_W-1:0] tgt;

  assign tgt         = {redirect_pc[WORD_W-1:2], 2'b00};
  assign pcp4        = pc + WORD_W'(PC_STEP);
  assign instr       = imem.iload;
  assign fetch_flush = redirect;
  assign imem.imemaddr = pc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= RUN;
      pc      <= PC_INIT[WORD_W-1:0];
      pend_pc <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      pend_pc <= pend_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    pend_n       = pend_pc;
    fetch_valid  = 1'b0;
    imem.imemREN = 1'b1;
    unique case (state)
      RUN: begin
        if (halt) begin
          state_n = HALTED;
        end else if (redirect) begin
          if (imem.ihit) begin
            pc_n = tgt;
          end else begin
            pend_n  = tgt;
            state_n = DRAIN;
          end
        end else if (!stall && imem.ihit) begin
          fetch_valid = 1'b1;
          pc_n        = pcp4;
        end
      end
      // Address held stable until the stale miss returns.
      DRAIN: begin
        if (halt) begin
          state_n = HALTED;
        end else if (redirect) begin
          pend_n = tgt;
          if (imem.ihit) begin
            pc_n    = tgt;
            state_n = RUN;
          end
        end else if (imem.ihit) begin
          pc_n    = pend_pc;
          state_n = RUN;
        end
      end
      HALTED: begin
        imem.imemREN = 1'b0;
      end
      default: begin
        state_n = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage against a queue-based model.
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] pcp4;
  logic        fetch_valid;
  logic        fetch_flush;
  logic [31:0] pc;

  fetch_stage_if #(.WORD_W(32)) bus ();

  fetch_stage #(
    .PC_INIT(32'h0),
    .WORD_W (32)
  ) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imem       (bus),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .instr      (instr),
    .pcp4       (pcp4),
    .fetch_valid(fetch_valid),
    .fetch_flush(fetch_flush),
    .pc         (pc)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic [31:0] ins;
    logic [31:0] p4;
    logic [31:0] pcv;
    logic        fv;
    logic        fl;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: PC, a parked target (queue of 0/1) and a halt flag.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_halt;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h t=%0t", nm, a, e, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("imemREN", {31'b0, bus.imemREN}, {31'b0, e.ren});
      chk("imemaddr", bus.imemaddr, e.addr);
      chk("instr", instr, e.ins);
      chk("pcp4", pcp4, e.p4);
      chk("pc", pc, e.pcv);
      chk("fetch_valid", {31'b0, fetch_valid}, {31'b0, e.fv});
      chk("fetch_flush", {31'b0, fetch_flush}, {31'b0, e.fl});
    end
  end

  task automatic model_reset();
    m_pc   = 32'h0;
    m_halt = 1'b0;
    m_pend.delete();
  endtask

  task automatic push_exp(input bit hit, input bit st, input bit rd,
                          input bit hl);
    exp_t e;
    e.ren  = !m_halt;
    e.addr = m_pc;
    e.pcv  = m_pc;
    e.p4   = m_pc + 32'd4;
    e.ins  = bus.iload;
    e.fl   = rd;
    e.fv   = nRST && !m_halt && m_pend.size() == 0 &&
             !hl && !rd && !st && hit;
    sb.push_back(e);
  endtask

  task automatic step(input bit hit, input bit st, input bit rd,
                      input logic [31:0] rpc, input bit hl);
    logic [31:0] t;
    bit          adv;
    nRST        = 1'b1;
    bus.ihit    = hit;
    bus.iload   = $urandom;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    t   = rpc & 32'hFFFF_FFFC;
    adv = !m_halt && m_pend.size() == 0 && !hl && !rd && !st && hit;
    push_exp(hit, st, rd, hl);
    if (m_halt) begin
    end else if (hl) begin
      m_halt = 1'b1;
      m_pend.delete();
    end else if (m_pend.size() > 0) begin
      if (rd) m_pend[0] = t;
      if (hit) m_pc = m_pend.pop_front();
    end else if (rd) begin
      if (hit) m_pc = t;
      else m_pend.push_back(t);
    end else if (adv) begin
      m_pc = m_pc + 32'd4;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    nRST        = 1'b0;
    bus.ihit    = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      bus.iload = $urandom;
      push_exp(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge CLK);
      #1;
    end
    nRST = 1'b1;
  endtask

  initial begin
    nRST        = 1'b0;
    bus.ihit    = 1'b0;
    bus.iload   = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    model_reset();
    @(posedge CLK);
    #1;
    do_reset(2);

    // Consecutive hits from reset
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);

    // Stall at 0x40
    step(1, 0, 1, 32'h40, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Redirect behind a miss at 0x100
    step(1, 0, 1, 32'h100, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h200, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Newest pending target wins, misaligned target
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h300, 0);
    step(0, 1, 1, 32'h403, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Halt beats redirect
    step(1, 0, 1, 32'h20, 0);
    step(1, 0, 1, 32'h500, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    do_reset(1);

    // PC wrap
    step(1, 0, 1, 32'hFFFF_FFFC, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Reset in the middle of a drain
    step(0, 0, 1, 32'h80, 0);
    step(0, 0, 1, 32'h600, 0);
    step(0, 0, 0, 0, 0);
    do_reset(1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if (m_halt && ($urandom % 6 == 0)) begin
        do_reset(1);
      end else begin
        step($urandom % 4 != 0, $urandom % 4 == 0,
             $urandom % 6 == 0, $urandom, $urandom % 90 == 0);
      end
    end

    bus.ihit = 1'b0;
    redirect = 1'b0;
    halt     = 1'b0;
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
